// File: rtl/spi_master_word.sv
// SPI master pulling WIDTH-bit words from a show-ahead FIFO: a word starts on the next ena, wrreq one clk after its last sample; stalls while empty.
// Define SPI_MASTER_CS_GAP_EN to hold n_cs high for CS_GAP bit periods between frames (otherwise one period).
module spi_master_word #(
    parameter int CLK_DIV_EVEN    = 8,
    parameter int WIDTH           = 8,
    parameter int CPOL            = 0,
    parameter int CPHA            = 0,
    parameter int LSB_FIRST       = 0,
    parameter int WORDS_PER_FRAME = 2,
    parameter int CS_GAP          = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sclk,
    output logic             n_cs,
    output logic             mosi,
    input  logic             miso,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_i,
    output logic             rdreq,
    output logic [WIDTH-1:0] miso_data,
    output logic             wrreq,
    output logic             ready
);
    localparam int            CW        = $clog2(CLK_DIV_EVEN);
    localparam int            BW        = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV_EVEN - 1);
    localparam logic [CW-1:0] CNT_LEAD  = CW'(CLK_DIV_EVEN / 4 - 1);
    localparam logic [CW-1:0] CNT_TRAIL = CW'(3 * CLK_DIV_EVEN / 4 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [7:0]    WPF       = 8'(WORDS_PER_FRAME);
    localparam logic          IDLE_LVL  = (CPOL != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef SPI_MASTER_CS_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic [7:0]       r_wcnt;
    logic [WIDTH-1:0] r_tx, r_rx, r_miso_data;
    logic [WIDTH-1:0] w_data_rest, w_tx_rest, w_rx_nxt;
    logic             r_done, r_sclk, r_ncs, r_mosi, r_wrreq;
    logic             w_ena, w_lead, w_trail, w_samp, w_shift;
    logic             w_first_bit, w_tx_bit, w_more, w_load, w_frame_end;

    // Edge events fire one clk early so sclk itself changes as cnt reaches CLK_DIV/4 and 3*CLK_DIV/4.
    assign w_ena   = (r_cnt == CNT_LAST);
    assign w_lead  = (r_cnt == CNT_LEAD);
    assign w_trail = (r_cnt == CNT_TRAIL);
    assign w_samp  = (CPHA == 0) ? w_lead : w_trail;
    assign w_shift = (CPHA == 0) ? w_ena : w_lead;

    assign w_first_bit = (LSB_FIRST != 0) ? data_i[0] : data_i[WIDTH-1];
    assign w_data_rest = (LSB_FIRST != 0) ? (data_i >> 1) : (data_i << 1);
    assign w_tx_bit    = (LSB_FIRST != 0) ? r_tx[0] : r_tx[WIDTH-1];
    assign w_tx_rest   = (LSB_FIRST != 0) ? (r_tx >> 1) : (r_tx << 1);
    assign w_rx_nxt    = (LSB_FIRST != 0) ? {miso, r_rx[WIDTH-1:1]} : {r_rx[WIDTH-2:0], miso};
    assign w_more      = !empty && ((WORDS_PER_FRAME == 0) || (r_wcnt < WPF));

`ifdef SPI_MASTER_CS_GAP_EN
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    logic [7:0] r_gap;

    // GAP covers all but the last gap period; the IDLE ena that starts the next frame is the final one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_gap <= 8'd0;
        else if (w_frame_end)
            r_gap <= 8'd1;
        else if (r_state == S_GAP && w_ena)
            r_gap <= r_gap + 8'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ena && !empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_ena && r_done) begin
                    if (w_more) begin
                        w_load = 1'b1;
                    end else begin
                        w_frame_end = 1'b1;
`ifdef SPI_MASTER_CS_GAP_EN
                        w_state_nxt = (CS_GAP > 1) ? S_GAP : S_IDLE;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
`ifdef SPI_MASTER_CS_GAP_EN
            S_GAP: begin
                if (w_ena && r_gap == GAP_LAST)
                    w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_sclk      <= IDLE_LVL;
            r_ncs       <= 1'b1;
            r_mosi      <= 1'b0;
            r_wrreq     <= 1'b0;
            r_miso_data <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit       <= '0;
            r_done      <= 1'b0;
            r_wcnt      <= '0;
        end else begin
            r_cnt   <= w_ena ? '0 : r_cnt + 1'b1;
            r_wrreq <= 1'b0;

            if (r_state == S_SHIFT && (w_lead || w_trail))
                r_sclk <= ~r_sclk;
            else if (r_state != S_SHIFT)
                r_sclk <= IDLE_LVL;

            if (w_load) begin
                r_ncs  <= 1'b0;
                r_bit  <= '0;
                r_done <= 1'b0;
                r_wcnt <= (r_state == S_IDLE) ? 8'd1 :
                          ((r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1);
                // CPHA=0 must present the first bit before the first leading edge.
                if (CPHA == 0) begin
                    r_mosi <= w_first_bit;
                    r_tx   <= w_data_rest;
                end else begin
                    r_tx   <= data_i;
                end
            end else if (w_frame_end) begin
                r_ncs  <= 1'b1;
                r_wcnt <= '0;
                r_done <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                if (w_shift) begin
                    r_mosi <= w_tx_bit;
                    r_tx   <= w_tx_rest;
                end
                if (w_samp) begin
                    r_rx <= w_rx_nxt;
                    if (r_bit == BIT_LAST) begin
                        r_done      <= 1'b1;
                        r_wrreq     <= 1'b1;
                        r_miso_data <= w_rx_nxt;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
            end
        end
    end

    assign sclk      = r_sclk;
    assign n_cs      = r_ncs;
    assign mosi      = r_mosi;
    assign rdreq     = w_load;
    assign wrreq     = r_wrreq;
    assign miso_data = r_miso_data;
    assign ready     = (r_state == S_IDLE);
endmodule

// File: tb/tb_spi_master_word.sv
// Directed bench for spi_master_word: three parameterisations with mosi->miso loopback and small FIFO models.
module tb_spi_master_word;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef SPI_MASTER_CS_GAP_EN
    localparam int EXP_GAP = 3 * 8;
`else
    localparam int EXP_GAP = 8;
`endif

    logic        sclk0, ncs0, mosi0, rd0, wr0, rdy0;
    logic        sclk1, ncs1, mosi1, rd1, wr1, rdy1;
    logic        sclk2, ncs2, mosi2, rd2, wr2, rdy2;
    logic [7:0]  md0, d0, md2, d2;
    logic [11:0] md1, d1;

    logic [31:0] mem [3][16];
    int          wp [3];
    int          rp [3];
    logic [2:0]  empty_v;
    assign empty_v = {wp[2] == rp[2], wp[1] == rp[1], wp[0] == rp[0]};
    assign d0 = mem[0][rp[0] % 16][7:0];
    assign d1 = mem[1][rp[1] % 16][11:0];
    assign d2 = mem[2][rp[2] % 16][7:0];

    spi_master_word #(.CS_GAP(3)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk0), .n_cs(ncs0), .mosi(mosi0), .miso(mosi0),
        .empty(empty_v[0]), .data_i(d0), .rdreq(rd0), .miso_data(md0), .wrreq(wr0), .ready(rdy0));
    spi_master_word #(.WIDTH(12), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk1), .n_cs(ncs1), .mosi(mosi1), .miso(mosi1),
        .empty(empty_v[1]), .data_i(d1), .rdreq(rd1), .miso_data(md1), .wrreq(wr1), .ready(rdy1));
    spi_master_word #(.WORDS_PER_FRAME(0)) u2 (
        .clk(clk), .rst(rst), .sclk(sclk2), .n_cs(ncs2), .mosi(mosi2), .miso(mosi2),
        .empty(empty_v[2]), .data_i(d2), .rdreq(rd2), .miso_data(md2), .wrreq(wr2), .ready(rdy2));

    logic [2:0]  sclk_v, ncs_v, mosi_v, rd_v, wr_v;
    logic [31:0] md_v [3];
    assign sclk_v = {sclk2, sclk1, sclk0};
    assign ncs_v  = {ncs2, ncs1, ncs0};
    assign mosi_v = {mosi2, mosi1, mosi0};
    assign rd_v   = {rd2, rd1, rd0};
    assign wr_v   = {wr2, wr1, wr0};
    assign md_v[0] = {24'd0, md0};
    assign md_v[1] = {20'd0, md1};
    assign md_v[2] = {24'd0, md2};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (rd_v[k]) rp[k] <= rp[k] + 1;
    end

    // Passive monitor: counts pulses/edges, captures mosi on rising sclk and n_cs low/high lengths.
    int          cyc;
    int          n_wr [3], n_rd [3], n_fall [3], n_sclk [3];
    int          t_edge [3], low_len [3], gap_len [3];
    logic [31:0] words [3][16];
    logic [31:0] bits [3];
    logic [2:0]  sclk_p = 3'b010;
    logic [2:0]  ncs_p  = 3'b111;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (wr_v[k]) begin
                words[k][n_wr[k] % 16] <= md_v[k];
                n_wr[k] <= n_wr[k] + 1;
            end
            if (rd_v[k]) n_rd[k] <= n_rd[k] + 1;
            if (!sclk_p[k] && sclk_v[k] && !ncs_v[k]) begin
                bits[k]   <= {bits[k][30:0], mosi_v[k]};
                n_sclk[k] <= n_sclk[k] + 1;
            end
            if (ncs_p[k] && !ncs_v[k]) begin
                n_fall[k]  <= n_fall[k] + 1;
                gap_len[k] <= cyc - t_edge[k];
                t_edge[k]  <= cyc;
            end
            if (!ncs_p[k] && ncs_v[k]) begin
                low_len[k] <= cyc - t_edge[k];
                t_edge[k]  <= cyc;
            end
        end
        sclk_p <= sclk_v;
        ncs_p  <= ncs_v;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        mem[k][wp[k] % 16] = v;
        wp[k] = wp[k] + 1;
    endtask

    task automatic wait_wr(input int k, input int target, input int budget, input string tag);
        int n = 0;
        while (n_wr[k] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n_wr[k] < target) chk({tag, " wrreq timeout"}, n_wr[k], target);
    endtask

    task automatic wait_fall(input int k, input int target, input int budget, input string tag);
        int n = 0;
        while (n_fall[k] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n_fall[k] < target) chk({tag, " n_cs timeout"}, n_fall[k], target);
    endtask

    int b_wr, b_rd, b_fall, b_sclk;

    task automatic snap(input int k);
        b_wr = n_wr[k]; b_rd = n_rd[k]; b_fall = n_fall[k]; b_sclk = n_sclk[k];
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst sclk cpol0", sclk0, 0);
        chk("rst sclk cpol1", sclk1, 1);
        chk("rst n_cs",       ncs0, 1);
        chk("rst mosi",       mosi0, 0);
        chk("rst rdreq",      rd0, 0);
        chk("rst wrreq",      wr0, 0);
        chk("rst miso_data",  md0, 0);
        chk("rst ready",      rdy0, 1);
        rst = 1'b0;

        // Two-word frame, MSB first.
        snap(0);
        push(0, 32'hA5); push(0, 32'h3C);
        wait_fall(0, b_fall + 1, 100, "A");
        @(negedge clk);
        chk("A ready busy", rdy0, 0);
        wait_wr(0, b_wr + 2, 400, "A");
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("A word0",  words[0][b_wr % 16], 32'hA5);
        chk("A word1",  words[0][(b_wr + 1) % 16], 32'h3C);
        chk("A rdreq",  n_rd[0] - b_rd, 2);
        chk("A frames", n_fall[0] - b_fall, 1);
        chk("A sclks",  n_sclk[0] - b_sclk, 16);
        chk("A mosi",   bits[0] & 32'hFFFF, 32'hA53C);
        chk("A cs low", low_len[0], 128);
        chk("A ready",  rdy0, 1);

        // 12-bit LSB first, CPOL=1, CPHA=1.
        snap(1);
        push(1, 32'h5A3);
        wait_wr(1, b_wr + 1, 600, "B");
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("B word",   words[1][b_wr % 16], 32'h5A3);
        chk("B mosi",   bits[1] & 32'hFFF, 32'hC5A);
        chk("B sclks",  n_sclk[1] - b_sclk, 12);
        chk("B cs low", low_len[1], 96);
        chk("B idle sclk", sclk1, 1);

        // Unlimited frame length: three words then FIFO runs dry.
        snap(2);
        push(2, 32'h11); push(2, 32'h22); push(2, 32'h33);
        wait_wr(2, b_wr + 3, 1000, "C");
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("C words", {8'd0, words[2][b_wr % 16][7:0], words[2][(b_wr + 1) % 16][7:0],
                        words[2][(b_wr + 2) % 16][7:0]}, 32'h112233);
        chk("C rdreq",  n_rd[2] - b_rd, 3);
        chk("C frames", n_fall[2] - b_fall, 1);
        chk("C cs low", low_len[2], 192);
        chk("C mosi",   bits[2] & 32'hFFFFFF, 32'h112233);

        // Single word in a two-word frame.
        snap(0);
        push(0, 32'h96);
        wait_wr(0, b_wr + 1, 400, "D");
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("D word",   words[0][b_wr % 16], 32'h96);
        chk("D rdreq",  n_rd[0] - b_rd, 1);
        chk("D wrreq",  n_wr[0] - b_wr, 1);
        chk("D cs low", low_len[0], 64);
        chk("D ready",  rdy0, 1);

        // Reset in the middle of bit 4 of a word.
        snap(0);
        push(0, 32'hC3);
        wait_fall(0, b_fall + 1, 100, "E");
        repeat (34) @(posedge clk);
        #2;
        chk("E mid sclk", sclk0, 1);
        chk("E mid n_cs", ncs0, 0);
        rst = 1'b1;
        #1;
        chk("E rst n_cs", ncs0, 1);
        chk("E rst sclk", sclk0, 0);
        chk("E rst wrreq", wr0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("E no wrreq", n_wr[0] - b_wr, 0);
        wp[0] = rp[0];
        rst = 1'b0;
        snap(0);
        push(0, 32'h5E);
        wait_wr(0, b_wr + 1, 400, "E");
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("E word after",  words[0][b_wr % 16], 32'h5E);
        chk("E mosi after",  bits[0] & 32'hFF, 32'h5E);
        chk("E cs low after", low_len[0], 64);

        // Four words, two per frame: check the inter-frame n_cs high time.
        snap(0);
        push(0, 32'h01); push(0, 32'h02); push(0, 32'h03); push(0, 32'h04);
        wait_wr(0, b_wr + 4, 1500, "F");
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("F frames", n_fall[0] - b_fall, 2);
        chk("F rdreq",  n_rd[0] - b_rd, 4);
        chk("F gap",    gap_len[0], EXP_GAP);
        chk("F cs low", low_len[0], 128);
        chk("F words",  {words[0][b_wr % 16][7:0], words[0][(b_wr + 1) % 16][7:0],
                         words[0][(b_wr + 2) % 16][7:0], words[0][(b_wr + 3) % 16][7:0]}, 32'h01020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
